// File: rtl/d2f_pkg.sv
// Shared defaults for the distance-to-frequency LED flasher and the derived
// divide-per-distance-unit scaling constant.
package d2f_pkg;

  localparam int D2F_WIDTH                  = 13;
  localparam int D2F_PERIOD_WIDTH           = 16;
  localparam int D2F_BASE_PERIOD            = 2000;
  localparam int D2F_DUTY_CYCLE             = 1000;
  localparam int D2F_MAX_FLASH_DISTANCE     = 2000;
  localparam int D2F_MIN_FLASH_DISTANCE     = 0;
  localparam int D2F_CLOCK_DIVIDE_LOW_FREQ  = 25000;
  localparam int D2F_CLOCK_DIVIDE_HIGH_FREQ = 5000;

  // Integer divide increment per distance unit across the flashing range.
  function automatic int d2f_scaling(input int low_div, input int high_div,
                                     input int max_dist, input int min_dist);
    return (low_div - high_div) / (max_dist - min_dist);
  endfunction

  localparam int D2F_DISTANCE2CLOCK_DIVIDE_SCALING =
    d2f_scaling(D2F_CLOCK_DIVIDE_LOW_FREQ, D2F_CLOCK_DIVIDE_HIGH_FREQ,
                D2F_MAX_FLASH_DISTANCE, D2F_MIN_FLASH_DISTANCE);

endpackage

// File: rtl/downcounter.sv
// Prescaler: counts down while enabled, reloads on zero; zero is combinational.
// Latency: zero reflects the registered count; disable clears the count to 0.
module downcounter
  import d2f_pkg::*;
#(
  parameter int PERIOD_WIDTH = D2F_PERIOD_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] reload,
  output logic [PERIOD_WIDTH-1:0] current_count,
  output logic                    zero
);

  logic [PERIOD_WIDTH-1:0] r_count;
  logic                    w_zero;

  assign w_zero = (r_count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (!enable) begin
      r_count <= '0;
    end else if (w_zero) begin
      r_count <= reload;
    end else begin
      r_count <= r_count - PERIOD_WIDTH'(1);
    end
  end

  assign current_count = r_count;
  assign zero          = w_zero;

endmodule

// File: rtl/distance_to_frequency_converter.sv
// Proximity LED flasher: distance picks a prescale divide whose strobe advances a fixed-duty PWM.
// New distance applies at the next prescaler reload; no backpressure. Macro D2F_OUT_OF_RANGE_OFF_EN darkens the LED at/after the far bound.
module distance_to_frequency_converter
  import d2f_pkg::*;
#(
  parameter int WIDTH                  = D2F_WIDTH,
  parameter int BASE_PERIOD            = D2F_BASE_PERIOD,
  parameter int DUTY_CYCLE             = D2F_DUTY_CYCLE,
  parameter int MAX_FLASH_DISTANCE     = D2F_MAX_FLASH_DISTANCE,
  parameter int MIN_FLASH_DISTANCE     = D2F_MIN_FLASH_DISTANCE,
  parameter int CLOCK_DIVIDE_LOW_FREQ  = D2F_CLOCK_DIVIDE_LOW_FREQ,
  parameter int CLOCK_DIVIDE_HIGH_FREQ = D2F_CLOCK_DIVIDE_HIGH_FREQ,
  parameter int PERIOD_WIDTH           = D2F_PERIOD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] distance,
  output logic             pwm_led
);

  localparam int DISTANCE2CLOCK_DIVIDE_SCALING =
    d2f_scaling(CLOCK_DIVIDE_LOW_FREQ, CLOCK_DIVIDE_HIGH_FREQ,
                MAX_FLASH_DISTANCE, MIN_FLASH_DISTANCE);
  localparam int DW    = WIDTH + PERIOD_WIDTH;
  localparam int PWM_W = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD) : 1;

  localparam logic [DW-1:0]    MIN_D    = DW'(MIN_FLASH_DISTANCE);
  localparam logic [DW-1:0]    MAX_D    = DW'(MAX_FLASH_DISTANCE);
  localparam logic [DW-1:0]    HIGH_D   = DW'(CLOCK_DIVIDE_HIGH_FREQ);
  localparam logic [DW-1:0]    SCALE_D  = DW'(DISTANCE2CLOCK_DIVIDE_SCALING);
  localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(BASE_PERIOD - 1);
  localparam logic [31:0]      DUTY_U   = 32'(DUTY_CYCLE);

  logic [DW-1:0]           w_dist_wide;
  logic                    w_in_range;
  logic [PERIOD_WIDTH-1:0] w_divide;
  logic [PERIOD_WIDTH-1:0] w_reload;
  logic [PERIOD_WIDTH-1:0] w_current_count;
  logic                    w_zero;
  logic                    w_pwm_enable;
  logic                    w_pwm_out;
  logic [PWM_W-1:0]        r_pwm_count;

  assign w_dist_wide = DW'(distance);
  assign w_in_range  = (w_dist_wide > MIN_D) && (w_dist_wide < MAX_D);

  // Product is formed at full width, then truncated to the prescaler width.
  assign w_divide = w_in_range
                  ? PERIOD_WIDTH'(HIGH_D + (w_dist_wide - MIN_D) * SCALE_D)
                  : PERIOD_WIDTH'(1);
  assign w_reload = w_divide - PERIOD_WIDTH'(1);

  downcounter #(
    .PERIOD_WIDTH (PERIOD_WIDTH)
  ) u_prescaler (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .reload        (w_reload),
    .current_count (w_current_count),
    .zero          (w_zero)
  );

  assert property (@(posedge clk) disable iff (reset)
                   (w_zero == (w_current_count == '0)));

  assign w_pwm_enable = w_zero & enable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pwm_count <= '0;
    end else if (!enable) begin
      r_pwm_count <= '0;
    end else if (w_pwm_enable) begin
      if (r_pwm_count == PWM_LAST) begin
        r_pwm_count <= '0;
      end else begin
        r_pwm_count <= r_pwm_count + PWM_W'(1);
      end
    end
  end

  assign w_pwm_out = (32'(r_pwm_count) < DUTY_U);

`ifdef D2F_OUT_OF_RANGE_OFF_EN
  logic w_too_far;
  assign w_too_far = (w_dist_wide >= MAX_D);
  assign pwm_led   = ~w_pwm_out & ~w_too_far;
`else
  assign pwm_led   = ~w_pwm_out;
`endif

endmodule

// File: tb/tb_distance_to_frequency_converter.sv
// Self-checking bench for the distance-to-frequency flasher with small overrides
// (period 4, duty 2, divide 2..12 across distance 0..10).
`timescale 1ns/1ps
module tb_distance_to_frequency_converter;

  localparam int BP = 4;
  localparam int DC = 2;
  localparam int HI = 2;
  localparam int LO = 12;
  localparam int MN = 0;
  localparam int MX = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [12:0] distance = '0;
  logic        pwm_led;
  logic        led_full;
  logic        led_dark;

  int errors = 0;
  int checks = 0;

  int m_strobes = 0;
  int m_wait = 0;
  bit exp_pat [8];

  always #5 clk = ~clk;

  distance_to_frequency_converter #(
    .WIDTH(13), .BASE_PERIOD(BP), .DUTY_CYCLE(DC),
    .MAX_FLASH_DISTANCE(MX), .MIN_FLASH_DISTANCE(MN),
    .CLOCK_DIVIDE_LOW_FREQ(LO), .CLOCK_DIVIDE_HIGH_FREQ(HI), .PERIOD_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .distance(distance), .pwm_led(pwm_led)
  );

  distance_to_frequency_converter #(
    .WIDTH(13), .BASE_PERIOD(BP), .DUTY_CYCLE(BP),
    .MAX_FLASH_DISTANCE(MX), .MIN_FLASH_DISTANCE(MN),
    .CLOCK_DIVIDE_LOW_FREQ(LO), .CLOCK_DIVIDE_HIGH_FREQ(HI), .PERIOD_WIDTH(16)
  ) dut_full (
    .clk(clk), .reset(reset), .enable(enable), .distance(distance), .pwm_led(led_full)
  );

  distance_to_frequency_converter #(
    .WIDTH(13), .BASE_PERIOD(BP), .DUTY_CYCLE(0),
    .MAX_FLASH_DISTANCE(MX), .MIN_FLASH_DISTANCE(MN),
    .CLOCK_DIVIDE_LOW_FREQ(LO), .CLOCK_DIVIDE_HIGH_FREQ(HI), .PERIOD_WIDTH(16)
  ) dut_dark (
    .clk(clk), .reset(reset), .enable(enable), .distance(distance), .pwm_led(led_dark)
  );

  // Reference: clocks between strobes follow the divide rule; LED lit in the
  // second part of each BP-strobe period.
  function automatic int ref_divide(input int d);
    if (d > MN && d < MX) return HI + (d - MN) * ((LO - HI) / (MX - MN));
    return 1;
  endfunction

  function automatic logic ref_led();
`ifdef D2F_OUT_OF_RANGE_OFF_EN
    if (int'(distance) >= MX) return 1'b0;
`endif
    return ((m_strobes % BP) >= DC);
  endfunction

  function automatic logic ref_dark();
`ifdef D2F_OUT_OF_RANGE_OFF_EN
    if (int'(distance) >= MX) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset || !enable) begin
      m_strobes = 0;
      m_wait    = 0;
    end else if (m_wait == 0) begin
      m_strobes = m_strobes + 1;
      m_wait    = ref_divide(int'(distance)) - 1;
    end else begin
      m_wait = m_wait - 1;
    end
    #1;
  endtask

  // Samples between two LED rising edges; ok=0 if the budget runs out.
  task automatic measure(input int budget, output int period, output int high_cnt, output bit ok);
    logic prev;
    int   n;
    ok = 1'b0; period = 0; high_cnt = 0;
    prev = pwm_led;
    n = 0;
    while (n < budget && !(prev == 1'b0 && pwm_led == 1'b1)) begin
      prev = pwm_led; tick(); n++;
    end
    if (!(prev == 1'b0 && pwm_led == 1'b1)) return;
    period = 1; high_cnt = 1;
    n = 0;
    forever begin
      prev = pwm_led; tick(); n++;
      if (prev == 1'b0 && pwm_led == 1'b1) begin ok = 1'b1; return; end
      if (n >= budget) return;
      period++;
      if (pwm_led) high_cnt++;
    end
  endtask

  task automatic wait_led_high(input int budget, output bit ok);
    int n = 0;
    while (pwm_led !== 1'b1 && n < budget) begin tick(); n++; end
    ok = (pwm_led === 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; distance = 13'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pwm_led !== 1'b0) begin errors++; $display("FAIL reset_hold: pwm_led=%0b want 0", pwm_led); end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (pwm_led !== 1'b0) begin errors++; $display("FAIL reset_release: pwm_led=%0b want 0", pwm_led); end
    exp_pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (pwm_led !== exp_pat[i]) begin errors++; $display("FAIL base_pattern[%0d]: pwm_led=%0b want %0b", i, pwm_led, exp_pat[i]); end
      checks++;
      if (pwm_led !== ref_led()) begin errors++; $display("FAIL base_model[%0d]: pwm_led=%0b want %0b", i, pwm_led, ref_led()); end
    end
  endtask

  task automatic test_in_range();
    int per, hi; bit ok;
    distance = 13'd5;
    measure(200, per, hi, ok);
    checks++;
    if (!ok || per != 28) begin errors++; $display("FAIL period_d5: got %0d (ok=%0b) want 28", per, ok); end
    checks++;
    if (hi != 14) begin errors++; $display("FAIL high_d5: got %0d want 14", hi); end
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (pwm_led !== ref_led()) begin errors++; $display("FAIL model_d5[%0d]: pwm_led=%0b want %0b", i, pwm_led, ref_led()); end
    end
  endtask

  task automatic test_out_of_range();
    int per, hi; bit ok; int bad;
    for (int k = 0; k < 2; k++) begin
      distance = (k == 0) ? 13'd10 : 13'd12;
`ifdef D2F_OUT_OF_RANGE_OFF_EN
      bad = 0;
      for (int i = 0; i < 16; i++) begin
        tick();
        if (pwm_led !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL dark_far[%0d]: %0d lit samples want 0", distance, bad); end
`else
      measure(100, per, hi, ok);
      checks++;
      if (!ok || per != 4 || hi != 2) begin
        errors++; $display("FAIL period_far[%0d]: period %0d high %0d ok %0b want 4/2", distance, per, hi, ok);
      end
`endif
    end
  endtask

  task automatic test_mid_change();
    int per, hi; bit ok;
    distance = 13'd5;
    for (int i = 0; i < 40; i++) tick();
    for (int i = 0; i < 3; i++) tick();
    distance = 13'd1;
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if (pwm_led !== ref_led()) begin errors++; $display("FAIL model_change[%0d]: pwm_led=%0b want %0b", i, pwm_led, ref_led()); end
    end
    measure(100, per, hi, ok);
    checks++;
    if (!ok || per != 12 || hi != 6) begin errors++; $display("FAIL period_d1: period %0d high %0d ok %0b want 12/6", per, hi, ok); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    wait_led_high(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL enable_setup: pwm_led=%0b want 1", pwm_led); end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (pwm_led !== 1'b0) begin errors++; $display("FAIL enable_low[%0d]: pwm_led=%0b want 0", i, pwm_led); end
    end
    enable = 1'b1;
    for (int i = 0; i < 26; i++) begin
      tick();
      checks++;
      if (pwm_led !== ref_led()) begin errors++; $display("FAIL reenable[%0d]: pwm_led=%0b want %0b", i, pwm_led, ref_led()); end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    wait_led_high(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL areset_setup: pwm_led=%0b want 1", pwm_led); end
    #2 reset = 1'b1;
    m_strobes = 0; m_wait = 0;
    #1;
    checks++;
    if (pwm_led !== 1'b0) begin errors++; $display("FAIL areset_immediate: pwm_led=%0b want 0", pwm_led); end
    #1 reset = 1'b0;
    for (int i = 0; i < 26; i++) begin
      tick();
      checks++;
      if (pwm_led !== ref_led()) begin errors++; $display("FAIL after_areset[%0d]: pwm_led=%0b want %0b", i, pwm_led, ref_led()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) distance = 13'($urandom_range(0, 15));
      if (enable && $urandom_range(0, 149) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      tick();
      checks++;
      if (pwm_led !== ref_led()) begin errors++; $display("FAIL random[%0d]: d=%0d en=%0b pwm_led=%0b want %0b", i, distance, enable, pwm_led, ref_led()); end
      if (i % 50 == 0) begin
        checks++;
        if (led_full !== 1'b0) begin errors++; $display("FAIL duty_full[%0d]: led=%0b want 0", i, led_full); end
        checks++;
        if (led_dark !== ref_dark()) begin errors++; $display("FAIL duty_zero[%0d]: led=%0b want %0b", i, led_dark, ref_dark()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_in_range();
    test_out_of_range();
    test_mid_change();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
